mopshub_frame_gen: RTL

- Parametrised, synthesizable successor of the bench data generator: generates uplink elink frames for the mopshub core across a programmable set of CAN buses.
- Sweeps enabled buses round-robin, a set number of frames per bus, with sign-on frames, optional looping, per-frame handshake and timeout supervision.
- Sits between the uplink stimulus/emulation side and the mopshub core's elink read interface.

---
 rtl/mopshub_frame_gen_pkg.sv | 48 ++++
 rtl/mopshub_frame_gen_if.sv | 22 ++
 rtl/mopshub_bus_sel.sv | 36 +++
 rtl/mopshub_frame_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_frame_gen_pkg.sv
// Shared types, constants and the frame-pack helper for the mopshub uplink frame generator.
package mopshub_frame_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_IRQ,
        ST_WAIT_START,
        ST_WAIT_END,
        ST_WAIT_CAN,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [10:0] COB_SIGN_ON = 11'h000;
    localparam logic [10:0] COB_SDO_RX  = 11'h601;

    // x^16 + x^14 + x^13 + x^11 + 1, feedback taken from bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned FRAME_MAX_W = 128;

    // Packs {bus_id, cob_id, seq, fill} MSB-first into the low payload_w bits;
    // fill is zero-extended or truncated to whatever width remains.
    function automatic logic [FRAME_MAX_W-1:0] pack_frame(
        input logic [31:0]  bus_id,
        input logic [10:0]  cob_id,
        input logic [31:0]  seq,
        input logic [15:0]  fill,
        input int unsigned  payload_w,
        input int unsigned  bus_w,
        input int unsigned  seq_w
    );
        logic [FRAME_MAX_W-1:0] ones;
        logic [FRAME_MAX_W-1:0] frame;
        int unsigned            fill_w;
        fill_w = payload_w - bus_w - 11 - seq_w;
        ones   = '1;
        frame  = FRAME_MAX_W'(fill) & (ones >> (FRAME_MAX_W - fill_w));
        frame  = frame | ((FRAME_MAX_W'(seq) & (ones >> (FRAME_MAX_W - seq_w))) << fill_w);
        frame  = frame | (FRAME_MAX_W'(cob_id) << (fill_w + seq_w));
        frame  = frame | ((FRAME_MAX_W'(bus_id) & (ones >> (FRAME_MAX_W - bus_w)))
                          << (fill_w + seq_w + 11));
        return frame;
    endfunction

endpackage

// File: rtl/mopshub_frame_gen_if.sv
// Elink read handshake between the frame generator (master) and the mopshub core (slave).
interface mopshub_frame_gen_if #(
    parameter int unsigned PAYLOAD_W = 76
);
    logic [PAYLOAD_W-1:0] payload;
    logic                 irq_elink;
    logic                 sign_on_sig;
    logic                 buffer_en;
    logic                 start_read_elink;
    logic                 end_read_elink;
    logic                 send_mes_can_done;

    modport master (
        output payload, irq_elink, sign_on_sig,
        input  buffer_en, start_read_elink, end_read_elink, send_mes_can_done
    );

    modport slave (
        input  payload, irq_elink, sign_on_sig,
        output buffer_en, start_read_elink, end_read_elink, send_mes_can_done
    );
endinterface

// File: rtl/mopshub_bus_sel.sv
// Combinational search for the next enabled bus above cur_idx, wrapping; wrap flags a pass through index 0.
module mopshub_bus_sel #(
    parameter int unsigned N_BUSES = 32,
    parameter int unsigned BUS_W   = 5
) (
    input  logic [N_BUSES-1:0] mask,
    input  logic [BUS_W-1:0]   cur_idx,
    output logic [BUS_W-1:0]   next_idx,
    output logic               wrap
);
    logic [N_BUSES-1:0] rot;
    int unsigned        shamt;
    int unsigned        off;
    int unsigned        sum;
    logic               found;

    // Rotating the doubled mask puts bus cur_idx+1 at bit 0, so the lowest set bit is the answer.
    always_comb begin
        shamt = 32'(cur_idx) + 1;
        rot   = N_BUSES'({mask, mask} >> shamt);
        found = 1'b0;
        off   = 0;
        for (int unsigned i = 0; i < N_BUSES; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        sum  = shamt + off;
        wrap = (sum >= N_BUSES);
        if (wrap) begin
            sum = sum - N_BUSES;
        end
        next_idx = BUS_W'(sum);
    end
endmodule

// File: rtl/mopshub_frame_gen.sv
// Uplink elink frame generator: round-robin sweep of enabled CAN buses with handshake and timeout.
// Define MOPSHUB_FRAME_GEN_LFSR_EN to take the fill field from a 16-bit LFSR instead of a counter.
module mopshub_frame_gen
    import mopshub_frame_gen_pkg::*;
#(
    parameter int unsigned PAYLOAD_W    = 76,
    parameter int unsigned N_BUSES      = 32,
    parameter int unsigned BUS_W        = 5,
    parameter int unsigned MAX_CNT_SIZE = 5,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    loop_en,
    input  logic [N_BUSES-1:0]      bus_mask,
    input  logic [MAX_CNT_SIZE-1:0] frames_per_bus,
    mopshub_frame_gen_if.master     elink,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [15:0]             frame_cnt
);
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
`ifdef MOPSHUB_FRAME_GEN_LFSR_EN
    localparam logic [15:0] FILL_INIT = LFSR_SEED;
`else
    localparam logic [15:0] FILL_INIT = 16'h0000;
`endif

    state_t                  state_q, state_d;
    logic [N_BUSES-1:0]      mask_q, mask_d;
    logic [MAX_CNT_SIZE-1:0] fpb_q, fpb_d;
    logic [BUS_W-1:0]        idx_q, idx_d;
    logic [MAX_CNT_SIZE-1:0] bus_cnt_q, bus_cnt_d;
    logic [MAX_CNT_SIZE-1:0] seq_q, seq_d;
    logic                    first_sweep_q, first_sweep_d;
    logic [15:0]             fill_q, fill_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [PAYLOAD_W-1:0]    payload_q, payload_d;

    logic [N_BUSES-1:0] sel_mask;
    logic [BUS_W-1:0]   sel_cur;
    logic [BUS_W-1:0]   sel_next;
    logic               sel_wrap;
    logic               sign_on;
    logic               in_wait;
    logic               in_frame;
    logic [15:0]        fill_next;

    // In IDLE the search starts from the top index so it yields the lowest bit of the live mask.
    assign sel_mask = (state_q == ST_IDLE) ? bus_mask : mask_q;
    assign sel_cur  = (state_q == ST_IDLE) ? BUS_W'(N_BUSES - 1) : idx_q;

    mopshub_bus_sel #(
        .N_BUSES (N_BUSES),
        .BUS_W   (BUS_W)
    ) u_bus_sel (
        .mask     (sel_mask),
        .cur_idx  (sel_cur),
        .next_idx (sel_next),
        .wrap     (sel_wrap)
    );

    assign sign_on  = first_sweep_q && (bus_cnt_q == '0);
    assign in_wait  = (state_q inside {ST_WAIT_START, ST_WAIT_END, ST_WAIT_CAN});
    assign in_frame = !(state_q inside {ST_IDLE, ST_DONE});

`ifdef MOPSHUB_FRAME_GEN_LFSR_EN
    assign fill_next = {fill_q[14:0], ^(fill_q & LFSR_TAPS)};
`else
    assign fill_next = fill_q + 16'd1;
`endif

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        fpb_d         = fpb_q;
        idx_d         = idx_q;
        bus_cnt_d     = bus_cnt_q;
        seq_d         = seq_q;
        first_sweep_d = first_sweep_q;
        fill_d        = fill_q;
        timeout_err_d = timeout_err_q;
        frame_cnt_d   = frame_cnt_q;
        payload_d     = payload_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d        = bus_mask;
                    fpb_d         = frames_per_bus;
                    idx_d         = sel_next;
                    bus_cnt_d     = '0;
                    seq_d         = '0;
                    first_sweep_d = 1'b1;
                    fill_d        = FILL_INIT;
                    timeout_err_d = 1'b0;
                    state_d       = (bus_mask != '0 && frames_per_bus != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (elink.buffer_en) begin
                    payload_d = PAYLOAD_W'(pack_frame(32'(idx_q),
                                                      sign_on ? COB_SIGN_ON : COB_SDO_RX,
                                                      32'(seq_q), fill_q,
                                                      PAYLOAD_W, BUS_W, MAX_CNT_SIZE));
                    fill_d    = fill_next;
                    state_d   = ST_IRQ;
                end
            end
            ST_IRQ: state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (elink.start_read_elink) begin
                    state_d = elink.end_read_elink ? ST_WAIT_CAN : ST_WAIT_END;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_WAIT_END: begin
                if (elink.end_read_elink) begin
                    state_d = ST_WAIT_CAN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_WAIT_CAN: begin
                if (elink.send_mes_can_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_NEXT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_NEXT: begin
                seq_d   = seq_q + 1'b1;
                state_d = ST_LOAD;
                if ((bus_cnt_q + 1'b1) == fpb_q) begin
                    bus_cnt_d = '0;
                    idx_d     = sel_next;
                    if (sel_wrap) begin
                        if (loop_en) begin
                            first_sweep_d = 1'b0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        tmo_cnt_d = (in_wait && state_d == state_q) ? tmo_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            fpb_q         <= '0;
            idx_q         <= '0;
            bus_cnt_q     <= '0;
            seq_q         <= '0;
            first_sweep_q <= 1'b0;
            fill_q        <= FILL_INIT;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= '0;
            payload_q     <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            fpb_q         <= fpb_d;
            idx_q         <= idx_d;
            bus_cnt_q     <= bus_cnt_d;
            seq_q         <= seq_d;
            first_sweep_q <= first_sweep_d;
            fill_q        <= fill_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
            payload_q     <= payload_d;
        end
    end

    assign elink.payload     = payload_q;
    assign elink.irq_elink   = (state_q == ST_IRQ);
    assign elink.sign_on_sig = in_frame && sign_on;
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);
    assign timeout_err       = timeout_err_q;
    assign frame_cnt         = frame_cnt_q;
endmodule
